result_display: RTL and testbench

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/display_pkg.sv | 50 +++++
 rtl/hex_to_seg7.sv | 12 +
 rtl/result_display.sv | 112 +++++++++++
 tb/tb_result_display.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the comparator result display: segment glyphs
// (active-low {dp,g,f,e,d,c,b,a}), display FSM states, and the bit layout
// of the comparator code field.
package display_pkg;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned SEG_W  = 8;
  localparam int unsigned DIG_W  = 2;
  localparam int unsigned AN_W   = 4;
  localparam int unsigned CNT_W  = 20;

  // Bit positions inside the comparator code field; bits 4:3 are reserved.
  localparam int unsigned CODE_EQ_BIT = 0;
  localparam int unsigned CODE_LT_BIT = 1;
  localparam int unsigned CODE_GT_BIT = 2;

  localparam logic [CODE_W-1:0] CODE_EQ = CODE_W'(1) << CODE_EQ_BIT;
  localparam logic [CODE_W-1:0] CODE_LT = CODE_W'(1) << CODE_LT_BIT;
  localparam logic [CODE_W-1:0] CODE_GT = CODE_W'(1) << CODE_GT_BIT;

  localparam logic [SEG_W-1:0] SEG_GT    = 8'hBB;
  localparam logic [SEG_W-1:0] SEG_LT    = 8'hAF;
  localparam logic [SEG_W-1:0] SEG_EQ    = 8'hB7;
  localparam logic [SEG_W-1:0] SEG_ERR_E = 8'h86;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Hex digit glyphs 0..F, decimal point always off.
  localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_SHOW  = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  // All-zero code means the comparator is disabled; a clean one-hot
  // relation is displayable; everything else is a malformed result.
  function automatic state_t decode_code(input logic [CODE_W-1:0] c);
    if (c == '0)
      return ST_BLANK;
    if (c == CODE_EQ || c == CODE_LT || c == CODE_GT)
      return ST_SHOW;
    return ST_ERR;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-digit to active-low 7-segment glyph decoder.
// Ports: i_hex - 4-bit nibble; o_seg_c - glyph {dp,g,f,e,d,c,b,a}, dp off.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [OPND_W-1:0] i_hex,
  output logic [SEG_W-1:0]  o_seg_c
);

  assign o_seg_c = SEG_HEX[i_hex];

endmodule

// File: rtl/result_display.sv
// Multiplexed 4-digit display of a comparator result: "a rel b _".
// Ports: clk, rst (async active-high); valid strobe captures a, b, code;
//        an - active-low digit enables (an[3] leftmost), registered;
//        seg - active-low segments {dp,g,f,e,d,c,b,a}, registered.
module result_display
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic [CODE_W-1:0] code,
  output logic [AN_W-1:0]   an,
  output logic [SEG_W-1:0]  seg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [OPND_W-1:0] r_a;
  logic [OPND_W-1:0] r_b;
  logic [CODE_W-1:0] r_code;
  logic [CNT_W-1:0]  r_cnt;
  logic [DIG_W-1:0]  r_dig;
  logic [AN_W-1:0]   r_an;
  logic [SEG_W-1:0]  r_seg;

  logic              w_cnt_wrap;
  logic [DIG_W-1:0]  w_dig_nxt;
  logic [SEG_W-1:0]  w_seg_a;
  logic [SEG_W-1:0]  w_seg_b;
  logic [SEG_W-1:0]  w_seg_rel;
  logic [SEG_W-1:0]  w_seg_nxt;

  hex_to_seg7 u_hex_a (.i_hex(r_a), .o_seg_c(w_seg_a));
  hex_to_seg7 u_hex_b (.i_hex(r_b), .o_seg_c(w_seg_b));

  // Free-running scan: digit index walks 3->2->1->0->3 on each wrap.
  assign w_cnt_wrap = (r_cnt == CNT_LAST);
  assign w_dig_nxt  = w_cnt_wrap ? (r_dig - DIG_W'(1)) : r_dig;

  // FSM next state: only a valid strobe moves the display mode.
  always_comb begin
    w_state_nxt = r_state;
    if (valid)
      w_state_nxt = decode_code(code);
  end

  // Relation glyph from the held code; only one-hot codes reach SHOW.
  always_comb begin
    w_seg_rel = SEG_EQ;
    case (r_code)
      CODE_GT: w_seg_rel = SEG_GT;
      CODE_LT: w_seg_rel = SEG_LT;
      default: w_seg_rel = SEG_EQ;
    endcase
  end

  // Glyph for the digit that becomes active on this edge, from held data,
  // so seg stays aligned with an and a capture shows one edge later.
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    case (r_state)
      ST_SHOW: begin
        case (w_dig_nxt)
          2'd3:    w_seg_nxt = w_seg_a;
          2'd2:    w_seg_nxt = w_seg_rel;
          2'd1:    w_seg_nxt = w_seg_b;
          default: w_seg_nxt = SEG_BLANK;
        endcase
      end
      ST_ERR: begin
        if (w_dig_nxt == 2'd3)
          w_seg_nxt = SEG_ERR_E;
      end
      default: w_seg_nxt = SEG_BLANK;
    endcase
  end

  // State, holding and scan registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_a     <= '0;
      r_b     <= '0;
      r_code  <= '0;
      r_cnt   <= '0;
      r_dig   <= '0;
      r_an    <= 4'b1110;
      r_seg   <= SEG_BLANK;
    end else begin
      r_state <= w_state_nxt;
      if (valid) begin
        r_a    <= a;
        r_b    <= b;
        r_code <= code;
      end
      r_cnt <= w_cnt_wrap ? '0 : (r_cnt + CNT_W'(1));
      r_dig <= w_dig_nxt;
      r_an  <= ~(AN_W'(1) << w_dig_nxt);
      r_seg <= w_seg_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

  localparam int unsigned DIV = 4;

  localparam logic [7:0] TB_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [4:0] code = '0;
  logic [3:0] an;
  logic [7:0] seg;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: edges since reset release, and the held capture.
  int         k = 0;
  logic [3:0] h_a = '0;
  logic [3:0] h_b = '0;
  logic [4:0] h_code = '0;

  result_display #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .valid(valid), .a(a), .b(b), .code(code),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Digit 0 for the first DIV edges, then 3, 2, 1, 0, ...
  function automatic int model_digit(input int edges);
    int adv;
    adv = edges / DIV;
    return (4 - (adv % 4)) % 4;
  endfunction

  function automatic logic [7:0] model_glyph(input logic [4:0] c, input logic [3:0] ha,
                                             input logic [3:0] hb, input int d);
    if (c == 5'd0) return 8'hFF;
    if (c[4:3] == 2'b00 && $countones(c[2:0]) == 1) begin
      if (d == 3) return TB_HEX[ha];
      if (d == 1) return TB_HEX[hb];
      if (d == 2) return c[2] ? 8'hBB : (c[1] ? 8'hAF : 8'hB7);
      return 8'hFF;
    end
    return (d == 3) ? 8'h86 : 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given inputs; checks an/seg against the model.
  task automatic step(input logic v, input logic [3:0] ta, input logic [3:0] tb_v,
                      input logic [4:0] tc);
    int d;
    logic [7:0] exp_seg;
    valid = v; a = ta; b = tb_v; code = tc;
    @(posedge clk); #1;
    k++;
    d = model_digit(k);
    exp_seg = model_glyph(h_code, h_a, h_b, d);
    if (v) begin
      h_a = ta; h_b = tb_v; h_code = tc;
    end
    chk("an", {4'b0, an}, {4'b0, ~(4'b0001 << d)});
    chk("seg", seg, exp_seg);
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 5'd0);
  endtask

  // Runs a full scan and checks each digit against explicit glyphs.
  task automatic check_digits(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                              input logic [7:0] e1, input logic [7:0] e0);
    logic [7:0] e;
    for (int i = 0; i < 4 * DIV; i++) begin
      step(1'b0, 4'h0, 4'h0, 5'd0);
      case (model_digit(k))
        3: e = e3;
        2: e = e2;
        1: e = e1;
        default: e = e0;
      endcase
      chk(tag, seg, e);
    end
  endtask

  initial begin
    // Reset held across edges.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", {4'b0, an}, 8'h0E);
    chk("rst_seg", seg, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    k = 0;

    // Scan only, no captures: blank throughout.
    idle(16);
    check_digits("blank_scan", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // a > b.
    step(1'b1, 4'h9, 4'h3, 5'b00100);
    check_digits("show_gt", 8'h90, 8'hBB, 8'hB0, 8'hFF);

    // a == b, then disabled comparator.
    step(1'b1, 4'hA, 4'hA, 5'b00001);
    check_digits("show_eq", 8'h88, 8'hB7, 8'h88, 8'hFF);
    step(1'b1, 4'h5, 4'h6, 5'b00000);
    check_digits("blank", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Malformed codes, then a < b.
    step(1'b1, 4'h1, 4'h2, 5'b00110);
    check_digits("err_multi", 8'h86, 8'hFF, 8'hFF, 8'hFF);
    step(1'b1, 4'h1, 4'h2, 5'b01000);
    check_digits("err_rsvd", 8'h86, 8'hFF, 8'hFF, 8'hFF);
    step(1'b1, 4'h1, 4'h2, 5'b00010);
    check_digits("show_lt", 8'hF9, 8'hAF, 8'hA4, 8'hFF);

    // Capture on the scan-wrap edge, then back-to-back captures.
    while (((k + 1) % DIV) != 0) step(1'b0, 4'h0, 4'h0, 5'd0);
    step(1'b1, 4'hC, 4'h7, 5'b00100);
    step(1'b1, 4'h2, 4'hD, 5'b00100);
    step(1'b1, 4'hF, 4'h0, 5'b00010);
    check_digits("b2b_last", 8'h8E, 8'hAF, 8'hC0, 8'hFF);

    // Randomized captures against the model.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] c;
      case ($urandom % 4)
        0: c = 5'(1) << ($urandom % 3);
        1: c = 5'd0;
        2: c = 5'($urandom);
        default: c = 5'(1) << ($urandom % 3);
      endcase
      step(($urandom % 10) < 3, 4'($urandom), 4'($urandom), c);
    end

    // Asynchronous reset mid-digit while showing data.
    step(1'b1, 4'h9, 4'h3, 5'b00100);
    idle(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", {4'b0, an}, 8'h0E);
    chk("arst_seg", seg, 8'hFF);
    @(posedge clk); #1;
    chk("arst_hold_an", {4'b0, an}, 8'h0E);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    h_a = '0; h_b = '0; h_code = '0;
    idle(6);
    check_digits("post_rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    // Held data reads 0 after reset: a SHOW code without new operands
    // is impossible, so capture zeros explicitly and compare glyphs.
    step(1'b1, 4'h0, 4'h0, 5'b00001);
    check_digits("post_rst_zero", 8'hC0, 8'hB7, 8'hC0, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
